// File: rtl/miinst_issue_sequencer.sv
// Bundle FIFO that issues non-NOP micro-op slots one per cycle in slot order; MIQ_PERF_CNT_EN adds perf counters.
// Latency: first op in the cycle after the bundle is accepted; 1 op/cycle, all-NOP bundles cost one bubble.
// Backpressure: in_ready drops while the FIFO is full; out_* hold steady while out_ready is low.
package miinst_pkg;
    localparam int MQ_N_DEFAULT = 7;

    typedef enum logic [3:0] {
        MIOP_NOP   = 4'd0,
        MIOP_SCALE = 4'd1,
        MIOP_LOAD  = 4'd2,
        MIOP_ADD   = 4'd3,
        MIOP_SUB   = 4'd4,
        MIOP_MUL   = 4'd5,
        MIOP_STORE = 4'd6,
        MIOP_RSRV  = 4'd7
    } miop_e;

    typedef struct packed {
        miop_e       op;
        logic [11:0] arg;
    } miinst_t;
endpackage

module miinst_issue_sequencer #(
    parameter int DEPTH = 4,
    parameter int MQ_N  = miinst_pkg::MQ_N_DEFAULT
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  miinst_pkg::miinst_t [MQ_N-1:0]   in_miinst,
    input  logic                             flush,
    output logic                             out_valid,
    input  logic                             out_ready,
    output miinst_pkg::miinst_t              out_miinst,
    output logic                             out_last,
    output logic                             empty
`ifdef MIQ_PERF_CNT_EN
    ,
    output logic [31:0]                      perf_issued,
    output logic [31:0]                      perf_nop_skipped
`endif
);
    import miinst_pkg::*;

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int SW = $clog2(MQ_N);
    localparam int IW = SW + 1;

    typedef miinst_t [MQ_N-1:0] bundle_t;
    typedef enum logic {ST_IDLE, ST_ISSUE} state_e;

    bundle_t       mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [IW-1:0] slot_idx_q, slot_idx_d;
    state_e        state_q, state_d;

    bundle_t       head;
    logic          full, push, pop, accept, issuing;
    logic          has_next, is_last;
    logic [SW-1:0] next_idx;

    assign head     = mem_q[rd_ptr_q[AW-1:0]];
    assign empty    = (rd_ptr_q == wr_ptr_q);
    assign full     = (rd_ptr_q[AW] != wr_ptr_q[AW]) && (rd_ptr_q[AW-1:0] == wr_ptr_q[AW-1:0]);
    assign in_ready = !full;
    assign push     = in_valid && !full && !flush;
    assign issuing  = (state_q == ST_ISSUE) && !empty;

    // Lowest non-NOP slot at or above slot_idx, and whether any non-NOP slot sits above it.
    always_comb begin
        has_next = 1'b0;
        next_idx = '0;
        is_last  = 1'b1;
        for (int k = 0; k < MQ_N; k++) begin
            if (head[k].op != MIOP_NOP) begin
                if (has_next) begin
                    is_last = 1'b0;
                end else if (IW'(k) >= slot_idx_q) begin
                    has_next = 1'b1;
                    next_idx = SW'(k);
                end
            end
        end
    end

    assign out_valid  = issuing && has_next;
    assign out_miinst = out_valid ? head[next_idx] : '0;
    assign out_last   = out_valid && is_last;
    assign accept     = out_valid && out_ready;
    assign pop        = issuing && (!has_next || (accept && is_last));

    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        slot_idx_d = slot_idx_q;
        if (push) wr_ptr_d = wr_ptr_q + PW'(1);
        if (pop) begin
            rd_ptr_d   = rd_ptr_q + PW'(1);
            slot_idx_d = '0;
        end else if (accept) begin
            slot_idx_d = IW'(next_idx) + IW'(1);
        end
        case (state_q)
            ST_IDLE:  if (push || !empty) state_d = ST_ISSUE;
            ST_ISSUE: if (pop && !push && ((rd_ptr_q + PW'(1)) == wr_ptr_q)) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
        if (flush) begin
            state_d    = ST_IDLE;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            slot_idx_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            slot_idx_q <= '0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            slot_idx_q <= slot_idx_d;
        end
    end

    // Payload storage needs no reset: the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q[AW-1:0]] <= in_miinst;
    end

`ifdef MIQ_PERF_CNT_EN
    logic [IW-1:0] nop_cnt;
    logic [31:0]   perf_issued_q, perf_nop_q;

    always_comb begin
        nop_cnt = '0;
        for (int k = 0; k < MQ_N; k++) begin
            if (head[k].op == MIOP_NOP) nop_cnt = nop_cnt + IW'(1);
        end
    end

    // A flushed head is discarded rather than popped, so its NOPs are not counted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_issued_q <= '0;
            perf_nop_q    <= '0;
        end else begin
            if (accept)        perf_issued_q <= perf_issued_q + 32'd1;
            if (pop && !flush) perf_nop_q    <= perf_nop_q + 32'(nop_cnt);
        end
    end

    assign perf_issued      = perf_issued_q;
    assign perf_nop_skipped = perf_nop_q;
`endif
endmodule

// File: tb/tb_miinst_issue_sequencer.sv
// Randomized and directed bench for miinst_issue_sequencer against a queue-based reference model.
module tb_miinst_issue_sequencer;
    localparam int DEPTH = 4;
    localparam int MQ_N  = miinst_pkg::MQ_N_DEFAULT;

    typedef miinst_pkg::miinst_t mi_t;
    typedef mi_t [MQ_N-1:0]      bundle_t;

    logic    clk = 1'b0;
    logic    rst, in_valid, flush, out_ready;
    logic    in_ready, out_valid, out_last, empty;
    bundle_t in_miinst;
    mi_t     out_miinst;
`ifdef MIQ_PERF_CNT_EN
    logic [31:0] perf_issued, perf_nop_skipped;
`endif

    int checks   = 0;
    int failures = 0;

    // Reference model: queue of buffered bundles plus the index of the next unissued slot of the head.
    bundle_t     mq[$];
    int          midx;
    int unsigned m_issued, m_nops;
    logic        exp_valid, exp_last, exp_in_ready, exp_empty;
    mi_t         exp_mi;
    int          exp_k;

    always #5 clk = ~clk;

    miinst_issue_sequencer #(.DEPTH(DEPTH), .MQ_N(MQ_N)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_miinst  (in_miinst),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_miinst (out_miinst),
        .out_last   (out_last),
        .empty      (empty)
`ifdef MIQ_PERF_CNT_EN
        ,
        .perf_issued      (perf_issued),
        .perf_nop_skipped (perf_nop_skipped)
`endif
    );

    function automatic bit is_nop(mi_t m);
        return m.op == miinst_pkg::MIOP_NOP;
    endfunction

    function automatic int nop_count(bundle_t b);
        int n = 0;
        for (int k = 0; k < MQ_N; k++) if (is_nop(b[k])) n++;
        return n;
    endfunction

    function automatic mi_t rnd_op();
        mi_t m;
        m.op  = miinst_pkg::miop_e'($urandom_range(1, 7));
        m.arg = 12'($urandom);
        return m;
    endfunction

    function automatic bundle_t mk_one(int slot);
        bundle_t b = '0;
        b[slot] = rnd_op();
        return b;
    endfunction

    function automatic bundle_t rnd_bundle();
        bundle_t b = '0;
        if ($urandom_range(0, 9) != 0)
            for (int k = 0; k < MQ_N; k++) if ($urandom_range(0, 9) >= 6) b[k] = rnd_op();
        return b;
    endfunction

    // Expected outputs for the current cycle, from the model's buffered bundles only.
    function automatic void predict();
        bundle_t h;
        int      lastk;
        exp_valid    = 1'b0;
        exp_last     = 1'b0;
        exp_mi       = '0;
        exp_k        = -1;
        exp_empty    = (mq.size() == 0);
        exp_in_ready = (mq.size() < DEPTH);
        if (mq.size() > 0) begin
            h     = mq[0];
            lastk = -1;
            for (int k = 0; k < MQ_N; k++) begin
                if (!is_nop(h[k])) begin
                    lastk = k;
                    if (exp_k < 0 && k >= midx) exp_k = k;
                end
            end
            if (exp_k >= 0) begin
                exp_valid = 1'b1;
                exp_mi    = h[exp_k];
                exp_last  = (exp_k == lastk);
            end
        end
    endfunction

    // Advance one clock: update the model from the inputs held across the edge, then re-predict.
    task automatic step();
        bit      do_push;
        bundle_t nb;
        @(posedge clk);
        nb      = in_miinst;
        do_push = in_valid && (mq.size() < DEPTH);
        if (rst) begin
            mq.delete(); midx = 0; m_issued = 0; m_nops = 0;
        end else if (flush) begin
            if (exp_valid && out_ready) m_issued++;
            mq.delete(); midx = 0;
        end else begin
            if (mq.size() > 0) begin
                if (!exp_valid) begin
                    m_nops += nop_count(mq[0]); void'(mq.pop_front()); midx = 0;
                end else if (out_ready) begin
                    m_issued++;
                    if (exp_last) begin
                        m_nops += nop_count(mq[0]); void'(mq.pop_front()); midx = 0;
                    end else begin
                        midx = exp_k + 1;
                    end
                end
            end
            if (do_push) mq.push_back(nb);
        end
        @(negedge clk);
        predict();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        checks++; if (in_ready !== 1'b1)  begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (out_last !== 1'b0)  begin failures++; $display("FAIL reset_out_last got=%b exp=0", out_last); end
        checks++; if (out_miinst !== '0)  begin failures++; $display("FAIL reset_out_miinst got=%h exp=0", out_miinst); end
        checks++; if (empty !== 1'b1)     begin failures++; $display("FAIL reset_empty got=%b exp=1", empty); end
`ifdef MIQ_PERF_CNT_EN
        checks++; if (perf_issued !== 32'd0 || perf_nop_skipped !== 32'd0) begin
            failures++; $display("FAIL reset_perf got=%0d/%0d exp=0/0", perf_issued, perf_nop_skipped); end
`endif
        rst = 1'b0;
        step();
    endtask

    task automatic test_basic();
        bundle_t b = '0;
        b[1].op = miinst_pkg::MIOP_LOAD;  b[1].arg = 12'h011;
        b[2].op = miinst_pkg::MIOP_ADD;   b[2].arg = 12'h022;
        b[3].op = miinst_pkg::MIOP_STORE; b[3].arg = 12'h033;
        in_valid = 1'b1; in_miinst = b; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++; if (out_valid !== 1'b1 || out_miinst !== b[i+1]) begin
                failures++; $display("FAIL basic_op%0d got=%b/%h exp=1/%h", i, out_valid, out_miinst, b[i+1]); end
            checks++; if (out_last !== 1'(i == 2)) begin
                failures++; $display("FAIL basic_last%0d got=%b exp=%b", i, out_last, i == 2); end
            step();
        end
        checks++; if (empty !== 1'b1 || out_valid !== 1'b0) begin
            failures++; $display("FAIL basic_drained got empty=%b valid=%b exp 1/0", empty, out_valid); end
    endtask

    task automatic test_fill();
        bundle_t bs[5];
        mi_t     got[$];
        int      pushed = 0;
        for (int i = 0; i < 5; i++) bs[i] = mk_one(2);
        for (int cyc = 0; cyc < 60 && got.size() < 5; cyc++) begin
            in_valid  = (pushed < 5);
            in_miinst = (pushed < 5) ? bs[pushed] : '0;
            out_ready = (cyc >= 6);
            checks++; if (in_ready !== exp_in_ready) begin
                failures++; $display("FAIL fill_in_ready cyc=%0d got=%b exp=%b", cyc, in_ready, exp_in_ready); end
            if (cyc == 4 || cyc == 6) begin
                checks++; if (in_ready !== 1'b0) begin
                    failures++; $display("FAIL fill_full cyc=%0d got=%b exp=0", cyc, in_ready); end
            end
            if (in_valid && in_ready) pushed++;
            if (out_valid && out_ready) got.push_back(out_miinst);
            step();
        end
        in_valid = 1'b0;
        checks++; if (got.size() != 5) begin failures++; $display("FAIL fill_count got=%0d exp=5", got.size()); end
        for (int i = 0; i < 5 && i < got.size(); i++) begin
            checks++; if (got[i] !== bs[i][2]) begin
                failures++; $display("FAIL fill_order%0d got=%h exp=%h", i, got[i], bs[i][2]); end
        end
    endtask

    task automatic test_stall();
        bundle_t b = '0;
        b[1] = rnd_op(); b[2] = rnd_op(); b[3] = rnd_op();
        in_valid = 1'b1; in_miinst = b; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        for (int i = 0; i < 4; i++) begin
            out_ready = (i == 3);
            checks++; if (out_valid !== 1'b1 || out_miinst !== b[2] || out_last !== 1'b0) begin
                failures++; $display("FAIL stall_hold%0d got=%b/%h/%b exp=1/%h/0", i, out_valid, out_miinst, out_last, b[2]); end
            step();
        end
        checks++; if (out_valid !== 1'b1 || out_miinst !== b[3] || out_last !== 1'b1) begin
            failures++; $display("FAIL stall_advance got=%b/%h/%b exp=1/%h/1", out_valid, out_miinst, out_last, b[3]); end
        step();
    endtask

    task automatic test_nop_bubble();
        bundle_t seq[3];
        mi_t     got[$];
        int      bubbles = 0;
`ifdef MIQ_PERF_CNT_EN
        logic [31:0] base = perf_nop_skipped;
`endif
        seq[0] = mk_one(0); seq[1] = '0; seq[2] = mk_one(MQ_N - 2);
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 12; cyc++) begin
            in_valid  = (cyc < 3);
            in_miinst = (cyc < 3) ? seq[cyc] : '0;
            checks++; if (out_valid !== exp_valid) begin
                failures++; $display("FAIL bubble_valid cyc=%0d got=%b exp=%b", cyc, out_valid, exp_valid); end
            if (!empty && !out_valid) bubbles++;
            if (out_valid) got.push_back(out_miinst);
            step();
        end
        in_valid = 1'b0;
        checks++; if (bubbles != 1) begin failures++; $display("FAIL bubble_count got=%0d exp=1", bubbles); end
        checks++; if (got.size() != 2 || got[0] !== seq[0][0] || got[1] !== seq[2][MQ_N-2]) begin
            failures++; $display("FAIL bubble_ops got_n=%0d exp_n=2", got.size()); end
`ifdef MIQ_PERF_CNT_EN
        checks++; if (perf_nop_skipped - base !== 32'(3 * MQ_N - 2)) begin
            failures++; $display("FAIL bubble_perf_nop got=%0d exp=%0d", perf_nop_skipped - base, 3 * MQ_N - 2); end
`endif
    endtask

    task automatic test_flush();
        bundle_t a = '0;
        bundle_t b = mk_one(3);
        bundle_t c = mk_one(1);
`ifdef MIQ_PERF_CNT_EN
        logic [31:0] base = perf_issued;
`endif
        a[0] = rnd_op(); a[1] = rnd_op(); a[2] = rnd_op();
        out_ready = 1'b0;
        in_valid = 1'b1; in_miinst = a; step();
        in_miinst = b; step();
        in_valid = 1'b0; out_ready = 1'b1;
        checks++; if (out_miinst !== a[0]) begin failures++; $display("FAIL flush_pre got=%h exp=%h", out_miinst, a[0]); end
        step();
        flush = 1'b1; in_valid = 1'b1; in_miinst = c;
        checks++; if (out_valid !== 1'b1 || out_miinst !== a[1]) begin
            failures++; $display("FAIL flush_mid got=%b/%h exp=1/%h", out_valid, out_miinst, a[1]); end
        step();
        flush = 1'b0; in_valid = 1'b0;
        checks++; if (out_valid !== 1'b0 || empty !== 1'b1 || in_ready !== 1'b1) begin
            failures++; $display("FAIL flush_after got valid=%b empty=%b rdy=%b exp 0/1/1", out_valid, empty, in_ready); end
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (out_valid !== 1'b0 || empty !== 1'b1) begin
                failures++; $display("FAIL flush_lost%0d got valid=%b empty=%b exp 0/1", i, out_valid, empty); end
        end
`ifdef MIQ_PERF_CNT_EN
        checks++; if (perf_issued - base !== 32'd2) begin
            failures++; $display("FAIL flush_perf_issued got=%0d exp=2", perf_issued - base); end
`endif
    endtask

    task automatic test_back_to_back();
        localparam int N = 16;
        bundle_t bs[N];
`ifdef MIQ_PERF_CNT_EN
        logic [31:0] base = perf_issued;
`endif
        for (int i = 0; i < N; i++) bs[i] = mk_one(int'($urandom_range(0, MQ_N - 1)));
        out_ready = 1'b1;
        for (int i = 0; i <= N; i++) begin
            in_valid  = (i < N);
            in_miinst = (i < N) ? bs[i] : '0;
            if (i > 0) begin
                checks++; if (out_valid !== 1'b1 || out_miinst !== exp_mi || exp_mi.op == miinst_pkg::MIOP_NOP) begin
                    failures++; $display("FAIL b2b_op%0d got=%b/%h exp=1/%h", i, out_valid, out_miinst, exp_mi); end
            end
            step();
        end
        in_valid = 1'b0;
        checks++; if (empty !== 1'b1) begin failures++; $display("FAIL b2b_empty got=%b exp=1", empty); end
`ifdef MIQ_PERF_CNT_EN
        checks++; if (perf_issued - base !== 32'(N)) begin
            failures++; $display("FAIL b2b_perf_issued got=%0d exp=%0d", perf_issued - base, N); end
`endif
    endtask

    task automatic test_random();
        for (int cyc = 0; cyc < 800; cyc++) begin
            in_valid  = ($urandom_range(0, 9) < 6);
            in_miinst = rnd_bundle();
            out_ready = ($urandom_range(0, 9) < 7);
            flush     = ($urandom_range(0, 49) == 0);
            checks++; if (in_ready !== exp_in_ready) begin
                failures++; $display("FAIL rnd_in_ready cyc=%0d got=%b exp=%b", cyc, in_ready, exp_in_ready); end
            checks++; if (empty !== exp_empty) begin
                failures++; $display("FAIL rnd_empty cyc=%0d got=%b exp=%b", cyc, empty, exp_empty); end
            checks++; if (out_valid !== exp_valid) begin
                failures++; $display("FAIL rnd_valid cyc=%0d got=%b exp=%b", cyc, out_valid, exp_valid); end
            if (exp_valid) begin
                checks++; if (out_miinst !== exp_mi || out_last !== exp_last) begin
                    failures++; $display("FAIL rnd_op cyc=%0d got=%h/%b exp=%h/%b", cyc, out_miinst, out_last, exp_mi, exp_last); end
            end
            step();
        end
        flush = 1'b0; in_valid = 1'b0;
`ifdef MIQ_PERF_CNT_EN
        checks++; if (perf_issued !== 32'(m_issued) || perf_nop_skipped !== 32'(m_nops)) begin
            failures++; $display("FAIL rnd_perf got=%0d/%0d exp=%0d/%0d", perf_issued, perf_nop_skipped, m_issued, m_nops); end
`endif
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_miinst = mk_one(i);
            step();
        end
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || empty !== 1'b0) begin
            failures++; $display("FAIL rstmid_pre got valid=%b empty=%b exp 1/0", out_valid, empty); end
        #2 rst = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0 || empty !== 1'b1 || in_ready !== 1'b1 || out_miinst !== '0 || out_last !== 1'b0) begin
            failures++; $display("FAIL rstmid_async got valid=%b empty=%b rdy=%b mi=%h exp 0/1/1/0", out_valid, empty, in_ready, out_miinst); end
        step();
        rst = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (out_valid !== 1'b0 || empty !== 1'b1) begin
                failures++; $display("FAIL rstmid_gone%0d got valid=%b empty=%b exp 0/1", i, out_valid, empty); end
        end
`ifdef MIQ_PERF_CNT_EN
        checks++; if (perf_issued !== 32'd0) begin failures++; $display("FAIL rstmid_perf got=%0d exp=0", perf_issued); end
`endif
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0; in_miinst = '0;
        midx = 0; m_issued = 0; m_nops = 0;
        @(negedge clk);
        predict();
        test_reset();
        test_basic();
        test_fill();
        test_stall();
        test_nop_bubble();
        test_flush();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
